// File: rtl/mem_bus_router.sv
// Core-side memory router: MMIO register block (GPIO, timer, status) plus a
// storage port with req/rvalid handshake and a wait timeout.
module mem_bus_router #(
  parameter int unsigned MEM_W          = 32,
  parameter int unsigned GPIO_N         = 16,
  parameter logic [31:0] MMIO_BASE      = 32'h0000_0100,
  parameter logic [31:0] SRAM_BASE      = 32'h0000_1000,
  parameter logic [31:0] EXT_BASE       = 32'h0000_2000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vproc_mem_req_o,
  input  logic [31:0]         vproc_mem_addr_o,
  input  logic                vproc_mem_we_o,
  input  logic [MEM_W/8-1:0]  vproc_mem_be_o,
  input  logic [MEM_W-1:0]    vproc_mem_wdata_o,
  output logic                vproc_mem_rvalid_i,
  output logic                vproc_mem_err_i,
  output logic [MEM_W-1:0]    vproc_mem_rdata_i,
  output logic                stor_req,
  output logic                stor_we,
  output logic [31:0]         stor_addr,
  output logic [MEM_W/8-1:0]  stor_be,
  output logic [MEM_W-1:0]    stor_wdata,
  input  logic                stor_rvalid,
  input  logic [MEM_W-1:0]    stor_rdata,
  input  logic                timer_is_high,
  output logic                set_timer,
  output logic [31:0]         timer_set_val,
  input  logic [GPIO_N-1:0]   gpio_i,
  output logic [GPIO_N-1:0]   gpio_o,
  output logic [GPIO_N-1:0]   gpio_oe
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, MMIO_RSP, STOR_WAIT, STOR_RSP} state_t;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [GPIO_N-1:0]   sync1, sync2;
  logic                drop, timeout;

  logic [31:0] off, wd32, mask32, rd32, oe_next, out_next;
  logic        is_stor, ext_wr, in_mmio, bad_addr;
  logic        sel_oe, sel_out, sel_in, sel_tim, sel_st;

  always_comb begin
    off      = vproc_mem_addr_o - MMIO_BASE;
    wd32     = vproc_mem_wdata_o[31:0];
    mask32   = {{8{vproc_mem_be_o[3]}}, {8{vproc_mem_be_o[2]}},
                {8{vproc_mem_be_o[1]}}, {8{vproc_mem_be_o[0]}}};
    is_stor  = vproc_mem_addr_o >= SRAM_BASE;
    ext_wr   = is_stor && vproc_mem_we_o && (vproc_mem_addr_o >= EXT_BASE);
    in_mmio  = !is_stor && (vproc_mem_addr_o >= MMIO_BASE);
    sel_oe   = in_mmio && (off == 32'h00);
    sel_out  = in_mmio && (off == 32'h04);
    sel_in   = in_mmio && (off == 32'h08);
    sel_tim  = in_mmio && (off == 32'h0C);
    sel_st   = in_mmio && (off == 32'h10);
    // GPIO_IN is read-only, so a write there falls into the error path too
    bad_addr = ext_wr ||
               (!is_stor && !(sel_oe || sel_out || (sel_in && !vproc_mem_we_o) ||
                              sel_tim || sel_st));
    oe_next  = (32'(gpio_oe) & ~mask32) | (wd32 & mask32);
    out_next = (32'(gpio_o)  & ~mask32) | (wd32 & mask32);
    rd32     = '0;
    if (sel_oe)  rd32 = 32'(gpio_oe);
    if (sel_out) rd32 = 32'(gpio_o);
    if (sel_in)  rd32 = 32'(sync2);
    if (sel_tim) rd32 = {31'b0, timer_is_high};
    if (sel_st)  rd32 = {30'b0, timeout, drop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      cnt                <= '0;
      sync1              <= '0;
      sync2              <= '0;
      drop               <= 1'b0;
      timeout            <= 1'b0;
      vproc_mem_rvalid_i <= 1'b0;
      vproc_mem_err_i    <= 1'b0;
      vproc_mem_rdata_i  <= '0;
      stor_req           <= 1'b0;
      stor_we            <= 1'b0;
      stor_addr          <= '0;
      stor_be            <= '0;
      stor_wdata         <= '0;
      set_timer          <= 1'b0;
      timer_set_val      <= '0;
      gpio_o             <= '0;
      gpio_oe            <= '0;
    end else begin
      sync1              <= gpio_i;
      sync2              <= sync1;
      vproc_mem_rvalid_i <= 1'b0;
      vproc_mem_err_i    <= 1'b0;
      vproc_mem_rdata_i  <= '0;
      set_timer          <= 1'b0;
      timer_set_val      <= '0;
      case (state)
        STOR_WAIT: begin
          if (vproc_mem_req_o) drop <= 1'b1;
          if (stor_rvalid) begin
            stor_req           <= 1'b0;
            vproc_mem_rvalid_i <= 1'b1;
            vproc_mem_rdata_i  <= stor_we ? '0 : stor_rdata;
            state              <= STOR_RSP;
          end else if (cnt == CW'(TIMEOUT_CYCLES)) begin
            stor_req        <= 1'b0;
            vproc_mem_err_i <= 1'b1;
            timeout         <= 1'b1;
            state           <= STOR_RSP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // IDLE and both response states accept a new request identically
        default: begin
          state <= IDLE;
          if (vproc_mem_req_o) begin
            if (bad_addr) begin
              vproc_mem_err_i <= 1'b1;
              state           <= MMIO_RSP;
            end else if (is_stor) begin
              stor_req   <= 1'b1;
              stor_we    <= vproc_mem_we_o;
              stor_addr  <= vproc_mem_addr_o;
              stor_be    <= vproc_mem_be_o;
              stor_wdata <= vproc_mem_wdata_o;
              cnt        <= CW'(1);
              state      <= STOR_WAIT;
            end else begin
              vproc_mem_rvalid_i <= 1'b1;
              state              <= MMIO_RSP;
              if (!vproc_mem_we_o) begin
                vproc_mem_rdata_i <= MEM_W'(rd32);
              end else begin
                if (sel_oe)  gpio_oe <= oe_next[GPIO_N-1:0];
                if (sel_out) gpio_o  <= out_next[GPIO_N-1:0];
                if (sel_tim && (|vproc_mem_be_o[3:0])) begin
                  set_timer     <= 1'b1;
                  timer_set_val <= wd32;
                end
                if (sel_st && vproc_mem_be_o[0]) begin
                  drop    <= drop    & ~wd32[0];
                  timeout <= timeout & ~wd32[1];
                end
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_router.sv
// Scoreboard bench for mem_bus_router: expected responses are queued when a
// request is driven and checked when rvalid/err appears.
module tb_mem_bus_router;

  localparam logic [31:0] MMIO = 32'h0000_0100;
  localparam logic [31:0] SRAM = 32'h0000_1000;
  localparam logic [31:0] EXT  = 32'h0000_2000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  be = '0;
  logic        rvalid, err;
  logic [31:0] rdata;
  logic        stor_req, stor_we, stor_rvalid = 1'b0;
  logic [31:0] stor_addr, stor_wdata, stor_rdata = '0;
  logic [3:0]  stor_be;
  logic        timer_is_high = 1'b0, set_timer;
  logic [31:0] timer_set_val;
  logic [15:0] gpio_i = '0, gpio_o, gpio_oe;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [32:0] exp_q[$];

  mem_bus_router #(
    .MEM_W(32), .GPIO_N(16), .MMIO_BASE(MMIO), .SRAM_BASE(SRAM),
    .EXT_BASE(EXT), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .vproc_mem_req_o(req), .vproc_mem_addr_o(addr), .vproc_mem_we_o(we),
    .vproc_mem_be_o(be), .vproc_mem_wdata_o(wdata),
    .vproc_mem_rvalid_i(rvalid), .vproc_mem_err_i(err), .vproc_mem_rdata_i(rdata),
    .stor_req(stor_req), .stor_we(stor_we), .stor_addr(stor_addr),
    .stor_be(stor_be), .stor_wdata(stor_wdata),
    .stor_rvalid(stor_rvalid), .stor_rdata(stor_rdata),
    .timer_is_high(timer_is_high), .set_timer(set_timer), .timer_set_val(timer_set_val),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one request for a single cycle; queue its response unless it is expected dropped.
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b,
                       input logic [31:0] d, input logic push,
                       input logic e_err, input logic [31:0] e_data);
    req = 1'b1; addr = a; we = w; be = b; wdata = d;
    if (push) exp_q.push_back({e_err, e_data});
    @(negedge clk);
    req = 1'b0; we = 1'b0; be = '0; wdata = '0;
  endtask

  always @(negedge clk) begin
    logic [32:0] e;
    if (rvalid && err) check_eq("rvalid_and_err", 1, 0);
    if (rvalid || err) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_rsp", {err, rvalid}, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_err", err, e[32]);
        check_eq("rsp_rdata", rdata, e[31:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned hi;
    repeat (3) @(negedge clk);
    check_eq("rst_rvalid", rvalid, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_stor_req", stor_req, 0);
    check_eq("rst_gpio_o", gpio_o, 0);
    check_eq("rst_gpio_oe", gpio_oe, 0);
    check_eq("rst_set_timer", set_timer, 0);
    rst = 1'b1;
    @(negedge clk);

    // GPIO writes and readback; upper 16 bits of OE write are discarded
    issue(MMIO + 32'h0, 1, 4'hF, 32'hFFFF_00FF, 1, 0, 0);
    check_eq("gpio_oe_wr", gpio_oe, 16'h00FF);
    issue(MMIO + 32'h4, 1, 4'hF, 32'h0000_00A5, 1, 0, 0);
    check_eq("gpio_o_wr", gpio_o, 16'h00A5);
    issue(MMIO + 32'h0, 0, 4'hF, 0, 1, 0, 32'h00FF);
    issue(MMIO + 32'h4, 0, 4'hF, 0, 1, 0, 32'h00A5);
    // byte-lane gating: only lane 0 updates
    issue(MMIO + 32'h4, 1, 4'h1, 32'h0000_FFFF, 1, 0, 0);
    check_eq("gpio_o_be", gpio_o, 16'h00FF);

    gpio_i = 16'h1234;
    repeat (4) @(negedge clk);
    issue(MMIO + 32'h8, 0, 4'hF, 0, 1, 0, 32'h1234);
    issue(MMIO + 32'h8, 1, 4'hF, 32'hFFFF_FFFF, 1, 1, 0);
    check_eq("gpio_oe_after_in_wr", gpio_oe, 16'h00FF);
    check_eq("gpio_o_after_in_wr", gpio_o, 16'h00FF);

    // Timer
    issue(MMIO + 32'hC, 1, 4'hF, 32'h0000_0064, 1, 0, 0);
    check_eq("set_timer_pulse", set_timer, 1);
    check_eq("timer_set_val", timer_set_val, 100);
    @(negedge clk);
    check_eq("set_timer_single", set_timer, 0);
    issue(MMIO + 32'hC, 1, 4'h0, 32'h0000_0055, 1, 0, 0);
    check_eq("set_timer_be0", set_timer, 0);
    timer_is_high = 1'b1;
    issue(MMIO + 32'hC, 0, 4'hF, 0, 1, 0, 32'h1);
    timer_is_high = 1'b0;

    // Back-to-back MMIO reads
    issue(MMIO + 32'h0, 0, 4'hF, 0, 1, 0, 32'h00FF);
    issue(MMIO + 32'h4, 0, 4'hF, 0, 1, 0, 32'h00FF);
    issue(MMIO + 32'h10, 0, 4'hF, 0, 1, 0, 32'h0);

    // Storage read with a dropped request during the wait
    issue(SRAM + 32'h40, 0, 4'hF, 0, 1, 0, 32'hDEAD_BEEF);
    check_eq("stor_req_rise", stor_req, 1);
    check_eq("stor_addr", stor_addr, SRAM + 32'h40);
    issue(MMIO + 32'h0, 0, 4'hF, 0, 0, 0, 0);
    @(negedge clk);
    stor_rvalid = 1'b1; stor_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    stor_rvalid = 1'b0; stor_rdata = '0;
    check_eq("stor_req_fall", stor_req, 0);
    issue(MMIO + 32'h10, 0, 4'hF, 0, 1, 0, 32'h1);
    issue(MMIO + 32'h10, 1, 4'hF, 32'h1, 1, 0, 0);
    issue(MMIO + 32'h10, 0, 4'hF, 0, 1, 0, 32'h0);
    // stor_rvalid outside the wait is ignored
    stor_rvalid = 1'b1;
    @(negedge clk);
    stor_rvalid = 1'b0;

    // Storage timeout
    issue(SRAM, 0, 4'hF, 0, 1, 1, 0);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      if (!stor_req) break;
      hi++;
      @(negedge clk);
    end
    check_eq("stor_req_cycles", hi, 8);
    issue(MMIO + 32'h10, 0, 4'hF, 0, 1, 0, 32'h2);
    issue(MMIO + 32'h10, 1, 4'hF, 32'h2, 1, 0, 0);
    issue(MMIO + 32'h10, 0, 4'hF, 0, 1, 0, 32'h0);

    // Error decodes
    issue(EXT + 32'h4, 1, 4'hF, 32'h1111_2222, 1, 1, 0);
    check_eq("ext_wr_no_req", stor_req, 0);
    issue(MMIO + 32'h14, 0, 4'hF, 0, 1, 1, 0);
    issue(MMIO + 32'h2, 0, 4'hF, 0, 1, 1, 0);
    issue(32'h0000_0010, 0, 4'hF, 0, 1, 1, 0);

    // Reset in the middle of a storage wait
    issue(SRAM + 32'h8, 0, 4'hF, 0, 0, 0, 0);
    check_eq("stor_req_pre_rst", stor_req, 1);
    #2 rst = 1'b0;
    #1 check_eq("stor_req_async_rst", stor_req, 0);
    repeat (2) @(negedge clk);
    check_eq("rst2_gpio_oe", gpio_oe, 0);
    check_eq("rst2_gpio_o", gpio_o, 0);
    check_eq("rst2_rvalid", rvalid, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst2_stor_req", stor_req, 0);
    issue(MMIO + 32'h0, 0, 4'hF, 0, 1, 0, 32'h0);
    issue(MMIO + 32'h10, 0, 4'hF, 0, 1, 0, 32'h0);
    repeat (3) @(negedge clk);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
